// File: rtl/apb_protocol_checker_pkg.sv
// Shared types and helpers for the APB protocol checker: FSM states, error
// codes, and width helpers used by the top and the select encoder.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE             = 3'd0,
    ERR_MULTI_SEL        = 3'd1,
    ERR_PSEL_DROP        = 3'd2,
    ERR_SETUP_NO_ACCESS  = 3'd3,
    ERR_CTRL_UNSTABLE    = 3'd4,
    ERR_TIMEOUT          = 3'd5,
    ERR_PENABLE_NO_SETUP = 3'd6
  } err_code_e;

  // Binary index width for a one-hot select of n bits; never narrower than 1.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle. The checker only observes, so it uses the monitor modport.
interface apb_protocol_checker_if #(
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int PRDATA_WIDTH = 32,
  parameter int NUM_SLAVES   = 16
);
  logic [PADDR_WIDTH-1:0]  paddr;
  logic                    prwd;
  logic [PWDATA_WIDTH-1:0] pwdata;
  logic                    penable;
  logic [NUM_SLAVES-1:0]   psel;
  logic                    pready;
  logic [PRDATA_WIDTH-1:0] prdata;
  logic                    pslverr;

  modport master  (output paddr, prwd, pwdata, penable, psel,
                   input  pready, prdata, pslverr);
  modport slave   (input  paddr, prwd, pwdata, penable, psel,
                   output pready, prdata, pslverr);
  modport monitor (input  paddr, prwd, pwdata, penable, psel,
                          pready, prdata, pslverr);
endinterface

// File: rtl/apb_protocol_checker_sel_encoder.sv
// Combinational psel decode: non-zero / one-hot flags and binary slave index.
module apb_sel_encoder
  import apb_chk_pkg::*;
#(
  parameter int NUM_SLAVES = 16
) (
  input  logic [NUM_SLAVES-1:0]            psel_i,
  output logic                             nonzero_o,
  output logic                             onehot_o,
  output logic [sel_width(NUM_SLAVES)-1:0] idx_o
);
  localparam int SEL_W = sel_width(NUM_SLAVES);

  logic [NUM_SLAVES-1:0] psel_m1;

  assign psel_m1   = psel_i - NUM_SLAVES'(1);
  assign nonzero_o = |psel_i;
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign onehot_o  = nonzero_o && ((psel_i & psel_m1) == '0);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_i[i]) idx_o = idx_o | SEL_W'(i);
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB monitor: tracks IDLE/SETUP/ACCESS, emits one-cycle transfer
// records and coded protocol-error pulses with a saturating error count.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int PRDATA_WIDTH   = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                                        pclock,
  input  logic                                        preset,
  input  logic                                        has_checks,
  apb_protocol_checker_if.monitor                     apb,
  output logic                                        xfer_valid,
  output logic                                        xfer_write,
  output logic [PADDR_WIDTH-1:0]                      xfer_addr,
  output logic [max_int(PWDATA_WIDTH,PRDATA_WIDTH)-1:0] xfer_data,
  output logic [sel_width(NUM_SLAVES)-1:0]            xfer_sel,
  output logic                                        xfer_slverr,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]         xfer_waits,
  output logic                                        err_valid,
  output logic [2:0]                                  err_code,
  output logic [ERR_CNT_WIDTH-1:0]                    err_count
);
  localparam int SEL_W   = sel_width(NUM_SLAVES);
  localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES+1);
  localparam int XDATA_W = max_int(PWDATA_WIDTH, PRDATA_WIDTH);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  state_e                  state_q, state_d;
  logic [PADDR_WIDTH-1:0]  addr_q;
  logic                    write_q;
  logic [PWDATA_WIDTH-1:0] wdata_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic [SEL_W-1:0]        sel_q;
  logic [WAIT_W-1:0]       wait_q, wait_d, wait_inc;

  logic                    xfer_valid_q, xfer_write_q, xfer_slverr_q;
  logic [PADDR_WIDTH-1:0]  xfer_addr_q;
  logic [XDATA_W-1:0]      xfer_data_q;
  logic [SEL_W-1:0]        xfer_sel_q;
  logic [WAIT_W-1:0]       xfer_waits_q;
  logic                    err_valid_q;
  err_code_e               err_code_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  logic             sel_nonzero, sel_onehot;
  logic [SEL_W-1:0] sel_idx;
  logic             capture, complete, ctrl_same, multi_sel;

  apb_sel_encoder #(.NUM_SLAVES(NUM_SLAVES)) u_sel_enc (
    .psel_i    (apb.psel),
    .nonzero_o (sel_nonzero),
    .onehot_o  (sel_onehot),
    .idx_o     (sel_idx)
  );

  assign multi_sel = sel_nonzero && !sel_onehot;
  assign ctrl_same = (apb.psel == psel_q) && (apb.paddr == addr_q) &&
                     (apb.prwd == write_q) && (!write_q || apb.pwdata == wdata_q);
  assign wait_inc  = wait_q + WAIT_W'(1);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = ERR_NONE;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (multi_sel) begin
          err_d = ERR_MULTI_SEL;
        end else if (sel_nonzero && apb.penable) begin
          err_d = ERR_PENABLE_NO_SETUP;
        end else if (sel_nonzero) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (multi_sel) begin
          err_d   = ERR_MULTI_SEL;
          state_d = ST_IDLE;
        end else if (!sel_nonzero) begin
          err_d   = ERR_PSEL_DROP;
          state_d = ST_IDLE;
        end else if (state_q == ST_SETUP && apb.psel == psel_q && !apb.penable) begin
          err_d   = ERR_SETUP_NO_ACCESS;
          capture = 1'b1;
        end else if (!ctrl_same || !apb.penable) begin
          // penable falling inside ACCESS is treated as unstable control
          err_d   = ERR_CTRL_UNSTABLE;
          state_d = ST_IDLE;
        end else if (apb.pready) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_ACCESS;
          wait_d  = WAIT_W'(1);
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(TIMEOUT_CYCLES)) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_ACCESS) wait_d = '0;
  end

  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      psel_q        <= '0;
      sel_q         <= '0;
      wait_q        <= '0;
      xfer_valid_q  <= 1'b0;
      xfer_write_q  <= 1'b0;
      xfer_addr_q   <= '0;
      xfer_data_q   <= '0;
      xfer_sel_q    <= '0;
      xfer_slverr_q <= 1'b0;
      xfer_waits_q  <= '0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_count_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (capture) begin
        addr_q  <= apb.paddr;
        write_q <= apb.prwd;
        wdata_q <= apb.pwdata;
        psel_q  <= apb.psel;
        sel_q   <= sel_idx;
      end
      xfer_valid_q <= complete;
      if (complete) begin
        xfer_write_q  <= write_q;
        xfer_addr_q   <= addr_q;
        xfer_data_q   <= write_q ? XDATA_W'(wdata_q) : XDATA_W'(apb.prdata);
        xfer_sel_q    <= sel_q;
        xfer_slverr_q <= apb.pslverr;
        xfer_waits_q  <= (state_q == ST_SETUP) ? '0 : wait_q;
      end
      err_valid_q <= has_checks && (err_d != ERR_NONE);
      if (has_checks && err_d != ERR_NONE) begin
        err_code_q  <= err_d;
        err_count_q <= sat_inc(err_count_q);
      end
    end
  end

  assign xfer_valid  = xfer_valid_q;
  assign xfer_write  = xfer_write_q;
  assign xfer_addr   = xfer_addr_q;
  assign xfer_data   = xfer_data_q;
  assign xfer_sel    = xfer_sel_q;
  assign xfer_slverr = xfer_slverr_q;
  assign xfer_waits  = xfer_waits_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker with TIMEOUT_CYCLES=4, ERR_CNT_WIDTH=2.
module tb_apb_protocol_checker;
  localparam int AW = 32, WW = 32, RW = 32, NS = 16, TO = 4, CW = 2;

  logic pclock = 1'b0;
  logic preset = 1'b1;
  logic has_checks = 1'b1;

  logic          xfer_valid, xfer_write, xfer_slverr, err_valid;
  logic [AW-1:0] xfer_addr;
  logic [31:0]   xfer_data;
  logic [3:0]    xfer_sel;
  logic [2:0]    xfer_waits;
  logic [2:0]    err_code;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  apb_protocol_checker_if #(.PADDR_WIDTH(AW), .PWDATA_WIDTH(WW),
                            .PRDATA_WIDTH(RW), .NUM_SLAVES(NS)) bus ();

  apb_protocol_checker #(
    .PADDR_WIDTH(AW), .PWDATA_WIDTH(WW), .PRDATA_WIDTH(RW),
    .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(CW)
  ) dut (
    .pclock(pclock), .preset(preset), .has_checks(has_checks), .apb(bus),
    .xfer_valid(xfer_valid), .xfer_write(xfer_write), .xfer_addr(xfer_addr),
    .xfer_data(xfer_data), .xfer_sel(xfer_sel), .xfer_slverr(xfer_slverr),
    .xfer_waits(xfer_waits), .err_valid(err_valid), .err_code(err_code),
    .err_count(err_count)
  );

  always #5 pclock = ~pclock;

  task automatic tick();
    @(posedge pclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.psel = '0; bus.penable = 1'b0; bus.pready = 1'b0;
    bus.paddr = '0; bus.prwd = 1'b0; bus.pwdata = '0;
    bus.prdata = '0; bus.pslverr = 1'b0;
  endtask

  task automatic setup(input logic [15:0] sel, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wdata);
    bus.psel = sel; bus.paddr = addr; bus.prwd = wr; bus.pwdata = wdata;
    bus.penable = 1'b0; bus.pready = 1'b0;
  endtask

  initial begin
    bus_idle();
    tick(); tick();
    chk("reset_xfer_valid", 64'(xfer_valid), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    preset = 1'b0;

    // write 0x1000 <- 0xDEADBEEF, slave 2, two wait states
    setup(16'h0004, 32'h1000, 1'b1, 32'hDEADBEEF);
    tick(); chk("wr_setup_xv", 64'(xfer_valid), 64'd0);
    bus.penable = 1'b1;
    tick(); chk("wr_wait1_xv", 64'(xfer_valid), 64'd0);
    tick(); chk("wr_wait2_xv", 64'(xfer_valid), 64'd0);
    bus.pready = 1'b1;
    tick();
    chk("wr_xv", 64'(xfer_valid), 64'd1);
    chk("wr_write", 64'(xfer_write), 64'd1);
    chk("wr_addr", 64'(xfer_addr), 64'h1000);
    chk("wr_data", 64'(xfer_data), 64'hDEADBEEF);
    chk("wr_sel", 64'(xfer_sel), 64'd2);
    chk("wr_waits", 64'(xfer_waits), 64'd2);
    chk("wr_err", 64'(err_valid), 64'd0);
    bus_idle();
    tick(); chk("wr_pulse_end", 64'(xfer_valid), 64'd0);

    // back-to-back read then write on slave 0
    setup(16'h0001, 32'h20, 1'b0, 32'h0);
    tick();
    bus.penable = 1'b1; bus.pready = 1'b1; bus.prdata = 32'h55;
    tick();
    chk("b2b_rd_xv", 64'(xfer_valid), 64'd1);
    chk("b2b_rd_write", 64'(xfer_write), 64'd0);
    chk("b2b_rd_data", 64'(xfer_data), 64'h55);
    chk("b2b_rd_sel", 64'(xfer_sel), 64'd0);
    chk("b2b_rd_waits", 64'(xfer_waits), 64'd0);
    setup(16'h0001, 32'h24, 1'b1, 32'h12345678);
    tick(); chk("b2b_gap_xv", 64'(xfer_valid), 64'd0);
    chk("b2b_gap_err", 64'(err_valid), 64'd0);
    bus.penable = 1'b1; bus.pready = 1'b1;
    tick();
    chk("b2b_wr_xv", 64'(xfer_valid), 64'd1);
    chk("b2b_wr_data", 64'(xfer_data), 64'h12345678);
    chk("b2b_wr_addr", 64'(xfer_addr), 64'h24);
    chk("b2b_wr_sel", 64'(xfer_sel), 64'd0);
    bus_idle(); tick();

    // multi-select in SETUP
    setup(16'h0001, 32'h40, 1'b0, 32'h0);
    tick();
    bus.psel = 16'h0003; bus.penable = 1'b1; bus.pready = 1'b1;
    tick();
    chk("multi_err", 64'(err_valid), 64'd1);
    chk("multi_code", 64'(err_code), 64'd1);
    chk("multi_cnt", 64'(err_count), 64'd1);
    chk("multi_xv", 64'(xfer_valid), 64'd0);
    bus_idle();
    tick(); chk("multi_pulse_end", 64'(err_valid), 64'd0);

    // address changes during ACCESS
    setup(16'h0002, 32'h10, 1'b0, 32'h0);
    tick();
    bus.penable = 1'b1;
    tick();
    bus.paddr = 32'h14;
    tick();
    chk("unst_err", 64'(err_valid), 64'd1);
    chk("unst_code", 64'(err_code), 64'd4);
    chk("unst_cnt", 64'(err_count), 64'd2);
    bus_idle(); tick();

    // same with checks disabled; FSM must still drop to IDLE
    has_checks = 1'b0;
    setup(16'h0002, 32'h10, 1'b0, 32'h0);
    tick();
    bus.penable = 1'b1;
    tick();
    bus.paddr = 32'h14;
    tick();
    chk("nochk_err", 64'(err_valid), 64'd0);
    chk("nochk_cnt", 64'(err_count), 64'd2);
    bus.pready = 1'b1;
    tick();
    chk("nochk_idle_xv", 64'(xfer_valid), 64'd0);
    chk("nochk_idle_err", 64'(err_valid), 64'd0);
    bus_idle(); has_checks = 1'b1; tick();

    // timeout on the 4th ACCESS sample
    setup(16'h0008, 32'h30, 1'b0, 32'h0);
    tick();
    bus.penable = 1'b1;
    tick(); chk("to_acc1", 64'(err_valid), 64'd0);
    tick(); chk("to_acc2", 64'(err_valid), 64'd0);
    tick(); chk("to_acc3", 64'(err_valid), 64'd0);
    tick();
    chk("to_err", 64'(err_valid), 64'd1);
    chk("to_code", 64'(err_code), 64'd5);
    chk("to_cnt", 64'(err_count), 64'd3);
    bus.pready = 1'b1;
    tick();
    chk("to_late_xv", 64'(xfer_valid), 64'd0);
    chk("to_late_code", 64'(err_code), 64'd6);
    chk("to_late_cnt_sat", 64'(err_count), 64'd3);
    bus_idle(); tick();

    // reset mid-ACCESS, released with penable high
    setup(16'h0001, 32'h50, 1'b0, 32'h0);
    tick();
    bus.penable = 1'b1;
    tick();
    preset = 1'b1;
    #1;
    chk("rst_cnt", 64'(err_count), 64'd0);
    chk("rst_addr", 64'(xfer_addr), 64'd0);
    chk("rst_data", 64'(xfer_data), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    bus.pready = 1'b1;
    tick();
    chk("rst_hold_xv", 64'(xfer_valid), 64'd0);
    chk("rst_hold_err", 64'(err_valid), 64'd0);
    preset = 1'b0;
    tick();
    chk("post_rst_err", 64'(err_valid), 64'd1);
    chk("post_rst_code", 64'(err_code), 64'd6);
    chk("post_rst_cnt", 64'(err_count), 64'd1);
    chk("post_rst_xv", 64'(xfer_valid), 64'd0);

    // drive the 2-bit counter into saturation with multi-select in IDLE
    bus.psel = 16'h0003;
    tick(); chk("sat_cnt2", 64'(err_count), 64'd2);
    tick(); chk("sat_cnt3", 64'(err_count), 64'd3);
    tick(); chk("sat_hold", 64'(err_count), 64'd3);
    chk("sat_code", 64'(err_code), 64'd1);
    bus_idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
